ifetch_unit: RTL and testbench

//  Instruction fetch front end; the producer side of the control interface.
//  - Fetches words from instruction memory over a req/ack handshake into a small prefetch buffer.
//  - Presents instr/op/funct to the control decoder with a valid/ready handshake.
//  - Consumes pcsrc/jump back from it to redirect the PC.
//  - Sits between imem and the datapath/controller; no branch delay slot.

---
 rtl/mips_pkg.sv | 20 ++
 rtl/ifetch_fifo.sv | 61 ++++++
 rtl/ifetch_unit.sv | 137 +++++++++++++
 tb/tb_ifetch_unit.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared types and constants for the instruction fetch front end.
package mips_pkg;

    // Memory-side fetch FSM states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        DRAIN = 2'd2
    } fetch_state_t;

    // One prefetch buffer entry: the instruction and the address it came from
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    localparam logic [5:0]  OP_J    = 6'b000010;
    localparam logic [31:0] PC_STEP = 32'd4;

endpackage

// File: rtl/ifetch_fifo.sv
// Prefetch buffer: DEPTH-entry FIFO of {pc, instr} with a synchronous flush
// that takes priority over push and pop. DEPTH must be a power of two >= 2.
module ifetch_fifo
    import mips_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    push,
    input  logic                    pop,
    input  logic                    flush,
    input  fetch_entry_t            wdata,
    output fetch_entry_t            rdata,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    full,
    output logic                    empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

    fetch_entry_t   mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic           do_push;
    logic           do_pop;

    assign empty   = (count == '0);
    assign full    = (count == FULL_CNT);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rd_ptr];

    // Pointer and occupancy tracking; flush empties the buffer in one cycle
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Entry storage; contents need no reset since count gates visibility
    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/ifetch_unit.sv
// Instruction fetch front end: imem req/ack fetch FSM, prefetch buffer and
// PC redirect on taken branch / jump at issue.
// Optional build macro IFETCH_PERF_CNT_EN adds saturating stall_cnt and
// flush_cnt outputs.
module ifetch_unit
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [5:0]  op,
    output logic [5:0]  funct,
    output logic [31:0] pc,
    output logic [31:0] pcplus4,
    input  logic        pcsrc,
    input  logic        jump,
    input  logic [31:0] pcbranch
`ifdef IFETCH_PERF_CNT_EN
    ,
    output logic [31:0] stall_cnt,
    output logic [31:0] flush_cnt
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

    fetch_state_t   state;
    logic [31:0]    fetch_pc;
    fetch_entry_t   head;
    fetch_entry_t   push_entry;
    logic [AW:0]    count;
    logic           empty;
    logic           unused_full;
    logic           unused_pcbranch;
    logic           pop;
    logic           push;
    logic           redirect;
    logic [31:0]    target;

    assign instr_valid = !empty;
    assign pop         = instr_valid && instr_ready;
    assign redirect    = pop && (jump || pcsrc);

    // Outputs read as zero while nothing is buffered
    assign instr   = empty ? '0 : head.instr;
    assign pc      = empty ? '0 : head.pc;
    assign op      = instr[31:26];
    assign funct   = instr[5:0];
    assign pcplus4 = pc + PC_STEP;

    // Jump has priority over a taken branch; branch targets are word-aligned
    assign target = jump ? {pcplus4[31:28], instr[25:0], 2'b00}
                         : {pcbranch[31:2], 2'b00};
    assign unused_pcbranch = ^pcbranch[1:0];

    // imem_addr equals fetch_pc for the whole WAIT state
    assign push       = (state == WAIT) && imem_ack && !redirect;
    assign push_entry = '{pc: imem_addr, instr: imem_rdata};

    ifetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (push),
        .pop     (pop),
        .flush   (redirect),
        .wdata   (push_entry),
        .rdata   (head),
        .count   (count),
        .full    (unused_full),
        .empty   (empty)
    );

    // Fetch FSM: one outstanding request; a redirect mid-request drains the
    // stale response before the new target is fetched
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            imem_req  <= 1'b0;
            imem_addr <= RESET_PC;
            fetch_pc  <= RESET_PC;
        end else begin
            if (redirect) fetch_pc <= target;
            unique case (state)
                IDLE: begin
                    if (!redirect && count < FULL_CNT) begin
                        imem_req  <= 1'b1;
                        imem_addr <= fetch_pc;
                        state     <= WAIT;
                    end
                end
                WAIT: begin
                    if (imem_ack) begin
                        imem_req <= 1'b0;
                        state    <= IDLE;
                        if (!redirect) fetch_pc <= fetch_pc + PC_STEP;
                    end else if (redirect) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (imem_ack) begin
                        imem_req <= 1'b0;
                        state    <= IDLE;
                    end
                end
                default: begin
                    imem_req <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end

`ifdef IFETCH_PERF_CNT_EN
    // Saturating counters of empty-issue cycles and redirects
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (!instr_valid && stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
            if (redirect && flush_cnt != '1)     flush_cnt <= flush_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_ifetch_unit.sv
// Bench for ifetch_unit: imem responder with configurable latency, consumer
// with random/forced redirects, and an architectural PC model that predicts
// the address and word of every issued instruction.
module tb_ifetch_unit;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        imem_req, imem_ack, instr_valid, instr_ready, pcsrc, jump;
    logic [31:0] imem_addr, imem_rdata, instr, pc, pcplus4, pcbranch;
    logic [5:0]  op, funct;

    logic        req1, ack1, valid1, ready1, pcsrc1, jump1;
    logic [31:0] addr1, rdata1, instr1, pc1, pcplus41, pcbranch1;
    logic [5:0]  op1, funct1;

`ifdef IFETCH_PERF_CNT_EN
    logic [31:0] stall_cnt, flush_cnt, stall_cnt1, flush_cnt1;
`endif

    always #5 clk = ~clk;

    ifetch_unit #(.RESET_PC(32'h0000_0000), .DEPTH(2)) dut (
        .clk(clk), .reset_n(reset_n),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr), .op(op), .funct(funct),
        .pc(pc), .pcplus4(pcplus4), .pcsrc(pcsrc), .jump(jump), .pcbranch(pcbranch)
`ifdef IFETCH_PERF_CNT_EN
        , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
    );

    ifetch_unit #(.RESET_PC(32'hFFFF_FFF8), .DEPTH(2)) dut_wrap (
        .clk(clk), .reset_n(reset_n),
        .imem_req(req1), .imem_addr(addr1), .imem_ack(ack1), .imem_rdata(rdata1),
        .instr_valid(valid1), .instr_ready(ready1), .instr(instr1), .op(op1), .funct(funct1),
        .pc(pc1), .pcplus4(pcplus41), .pcsrc(pcsrc1), .jump(jump1), .pcbranch(pcbranch1)
`ifdef IFETCH_PERF_CNT_EN
        , .stall_cnt(stall_cnt1), .flush_cnt(flush_cnt1)
`endif
    );

    int          nchk = 0, nerr = 0;
    logic [31:0] seed;
    logic [31:0] ovr [logic [31:0]];
    logic [31:0] exp_pc, last_pc, e1;
    bit          busy;
    int          wcnt, lat_lo, lat_hi, redir_pct, npops, ms, mf, n1;
    bit          f_armed, f_fired, f_jump, f_pcsrc;
    logic [31:0] f_at, f_br;

    // Instruction memory contents: a scrambled function of the address
    function automatic logic [31:0] memw(input logic [31:0] a);
        if (ovr.exists(a)) return ovr[a];
        return (a * 32'h9E37_79B1) ^ seed;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        nchk++;
        assert (obs === expv) else begin
            nerr++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic do_reset(input bit late_ack);
        reset_n = 1'b0;
        imem_ack = 1'b0; imem_rdata = '0; instr_ready = 1'b0;
        pcsrc = 1'b0; jump = 1'b0; pcbranch = '0;
        ack1 = 1'b0; rdata1 = '0; ready1 = 1'b0; pcsrc1 = 1'b0; jump1 = 1'b0; pcbranch1 = '0;
        busy = 1'b0; f_armed = 1'b0; f_fired = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_req", {31'd0, imem_req}, 32'd0);
        chk("rst_addr", imem_addr, 32'h0);
        chk("rst_valid", {31'd0, instr_valid}, 32'd0);
        chk("rst_instr", instr, 32'h0);
        chk("rst_pc", pc, 32'h0);
        chk("rst_opfn", {20'd0, op, funct}, 32'd0);
        chk("rst_addr_wrap", addr1, 32'hFFFF_FFF8);
`ifdef IFETCH_PERF_CNT_EN
        chk("rst_stall_cnt", stall_cnt, 32'd0);
        chk("rst_flush_cnt", flush_cnt, 32'd0);
`endif
        reset_n = 1'b1;
        // A response left over from before reset arrives as the reset lifts
        if (late_ack) begin imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF; end
        exp_pc = 32'h0; npops = 0;
        ms = 1;  // buffer is empty on the first edge after release
        mf = 0;
    endtask

    // One cycle: act as imem and as the consumer, checking every issued word
    task automatic tick(input int rdy);
        logic [31:0] w;
        logic        j, b;
        @(negedge clk);
`ifdef IFETCH_PERF_CNT_EN
        chk("stall_cnt", stall_cnt, ms);
        chk("flush_cnt", flush_cnt, mf);
        if (!instr_valid) ms++;
`endif
        imem_ack = 1'b0;
        imem_rdata = $urandom;
        if (imem_req) begin
            if (!busy) begin busy = 1'b1; wcnt = $urandom_range(lat_lo, lat_hi); end
            if (wcnt == 0) begin
                imem_ack = 1'b1; imem_rdata = memw(imem_addr); busy = 1'b0;
            end else wcnt--;
        end
        instr_ready = 1'b0; pcsrc = 1'b0; jump = 1'b0; pcbranch = $urandom;
        if (instr_valid)
            instr_ready = (rdy == 1) || (rdy == 2 && $urandom_range(0, 1) == 1);
        else if (rdy == 2)
            instr_ready = $urandom_range(0, 1) == 1;
        if (instr_valid && instr_ready) begin
            w = memw(exp_pc);
            chk("pc", pc, exp_pc);
            chk("instr", instr, w);
            chk("op", {26'd0, op}, {26'd0, w[31:26]});
            chk("funct", {26'd0, funct}, {26'd0, w[5:0]});
            chk("pcplus4", pcplus4, exp_pc + 32'd4);
            npops++; last_pc = pc;
            j = 1'b0; b = 1'b0;
            if (f_armed && exp_pc == f_at) begin
                j = f_jump; b = f_pcsrc; pcbranch = f_br; f_armed = 1'b0; f_fired = 1'b1;
            end else if ($urandom_range(0, 99) < redir_pct) begin
                j = $urandom_range(0, 1) == 1;
                b = !j || ($urandom_range(0, 1) == 1);
            end
            jump = j; pcsrc = b;
            if (j)      exp_pc = ((exp_pc + 32'd4) & 32'hF000_0000) | ((w & 32'h03FF_FFFF) << 2);
            else if (b) exp_pc = pcbranch & 32'hFFFF_FFFC;
            else        exp_pc = exp_pc + 32'd4;
            if (j || b) mf++;
        end else if (rdy == 2) begin
            // redirect inputs without a pop must be ignored
            pcsrc = $urandom_range(0, 1) == 1;
            jump  = $urandom_range(0, 1) == 1;
        end
    endtask

    initial begin
        seed = $urandom;
        lat_lo = 0; lat_hi = 0; redir_pct = 0;

        // 1: ack every cycle, always ready
        do_reset(1'b0);
        tick(1);
        chk("t1_first_req", {31'd0, imem_req}, 32'd1);
        chk("t1_first_addr", imem_addr, 32'h0);
        repeat (11) tick(1);
        chk("t1_pops", {31'd0, npops >= 3}, 32'd1);

        // 2: consumer stalled; buffer fills to DEPTH then requests stop
        do_reset(1'b0);
        for (int i = 0; i < 8; i++) begin
            tick(0);
            if (i >= 3) chk("t2_noreq", {31'd0, imem_req}, 32'd0);
        end
        chk("t2_valid", {31'd0, instr_valid}, 32'd1);
        chk("t2_head_pc", pc, 32'h0);

        // 3: taken branch at pc 0x8 while the 0xC fetch is outstanding
        tick(1);                          // pop 0x0
        repeat (3) tick(0);               // fetch 0x8 into the freed slot
        chk("t3_full_noreq", {31'd0, imem_req}, 32'd0);
        chk("t3_head_pc", pc, 32'h4);
        lat_lo = 3; lat_hi = 3;
        f_armed = 1'b1; f_at = 32'h8; f_jump = 1'b0; f_pcsrc = 1'b1; f_br = 32'h40;
        tick(1);                          // pop 0x4
        tick(0);                          // 0xC request issues
        tick(1);                          // pop 0x8 with branch, 0xC still pending
        chk("t3_fired", {31'd0, f_fired}, 32'd1);
        tick(0);
        chk("t3_drain_req", {31'd0, imem_req}, 32'd1);
        chk("t3_drain_addr", imem_addr, 32'hC);
        chk("t3_flushed", {31'd0, instr_valid}, 32'd0);
        tick(0); tick(0);                 // late ack for 0xC arrives here
        lat_lo = 0; lat_hi = 0;
        tick(0);
        chk("t3_idle", {31'd0, imem_req}, 32'd0);
        tick(0);
        chk("t3_new_req", {31'd0, imem_req}, 32'd1);
        chk("t3_new_addr", imem_addr, 32'h40);
        tick(1);
        chk("t3_issued_pc", last_pc, 32'h40);

        // 4: jump and branch together at pc 0x1000_0000; jump wins
        ovr[32'h1000_0000] = 32'h0800_0010;
        f_fired = 1'b0;
        f_armed = 1'b1; f_at = exp_pc; f_jump = 1'b0; f_pcsrc = 1'b1; f_br = 32'h1000_0000;
        for (int i = 0; i < 10 && !f_fired; i++) tick(1);
        chk("t4_branch_fired", {31'd0, f_fired}, 32'd1);
        repeat (8) tick(0);
        chk("t4_buf_full", {30'd0, imem_req, instr_valid}, 32'd1);
        f_fired = 1'b0;
        f_armed = 1'b1; f_at = 32'h1000_0000; f_jump = 1'b1; f_pcsrc = 1'b1; f_br = 32'h2000_0000;
        tick(1);
        chk("t4_jump_fired", {31'd0, f_fired}, 32'd1);
        tick(0);
        chk("t4_flushed", {31'd0, instr_valid}, 32'd0);
        n1 = npops;
        for (int i = 0; i < 10 && npops == n1; i++) tick(1);
        chk("t4_target", last_pc, 32'h1000_0040);

        // 5: PC wraps past the top of the address space
        do_reset(1'b0);
        e1 = 32'hFFFF_FFF8; n1 = 0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            ack1 = req1; rdata1 = memw(addr1); ready1 = valid1;
            if (valid1 && n1 < 3) begin
                chk("t5_pc", pc1, e1);
                chk("t5_instr", instr1, memw(e1));
                e1 = e1 + 32'd4; n1++;
            end
        end
        chk("t5_count", n1, 32'd3);

        // Random traffic: random latency, readiness and redirects
        do_reset(1'b0);
        lat_lo = 0; lat_hi = 3; redir_pct = 15;
        repeat (400) tick(2);
        chk("rand_progress", {31'd0, npops > 50}, 32'd1);

        // 6: reset asserted mid-request, stale ack at release
        redir_pct = 0;
        do_reset(1'b0);
        lat_lo = 10; lat_hi = 10;
        tick(0);
        chk("t6_in_wait", {31'd0, imem_req}, 32'd1);
        reset_n = 1'b0;
        #1;
        chk("t6_req_async", {31'd0, imem_req}, 32'd0);
        do_reset(1'b1);
        lat_lo = 0; lat_hi = 0;
        tick(1);
        chk("t6_first_req", {31'd0, imem_req}, 32'd1);
        chk("t6_first_addr", imem_addr, 32'h0);
        repeat (5) tick(1);
        chk("t6_pops", {31'd0, npops >= 2}, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

endmodule
